// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the decode-stage hazard inputs and the pipeline-register control
// outputs of pipeline_hazard_ctrl.
//   master : decoder / pipeline side (drives hazard inputs, observes controls)
//   slave  : hazard controller (consumes hazard inputs, drives controls)
// Signals:
//   id_opcode[5:0], id_rs[4:0], id_rt[4:0], id_uses_rt   instruction in ID
//   ex_opcode[5:0], ex_rd[4:0], ex_branch_tkn            ID/EX contents
//   pc_we, ifid_we, ifid_flush, idex_we, idex_bubble     pipeline controls
//   mc_busy, mc_done                                     multi-cycle status
//   stall_count[CNT_W-1:0]                               stall performance counter
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [5:0]       ex_opcode;
    logic [4:0]       ex_rd;
    logic             ex_branch_tkn;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_bubble;
    logic             mc_busy;
    logic             mc_done;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_opcode, id_rs, id_rt, id_uses_rt, ex_opcode, ex_rd, ex_branch_tkn,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, mc_busy, mc_done,
        input  stall_count
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, id_uses_rt, ex_opcode, ex_rd, ex_branch_tkn,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, mc_busy, mc_done,
        output stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Decode-stage hazard controller for the 5-stage core. Sequences the IF/ID
// and ID/EX registers around load-use hazards, taken-branch flushes and
// multi-cycle EX operations, and counts cycles in which the PC is held.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      pipeline_hazard_ctrl_if.slave (hazard inputs in, controls out)
// Control outputs are combinational from state and inputs; only the FSM
// state, the multi-cycle down-counter and the stall counter are registered.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter logic [5:0] OPC_LW     = 6'h23,
    parameter logic [5:0] OPC_MC     = 6'h1C,
    parameter int         MC_LATENCY = 4,
    parameter int         CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MC_WAIT = 1'b1;

    // The RUN cycle that launches the op is already one stall cycle, so the
    // counter covers the remaining MC_LATENCY-2 stalling MC_WAIT cycles.
    localparam logic [3:0] MC_INIT = 4'(MC_LATENCY - 2);

    logic [0:0]       r_state;
    logic [3:0]       r_mc_cnt;
    logic [CNT_W-1:0] r_stall_count;

    logic [0:0]       w_state_next;
    logic [3:0]       w_mc_cnt_next;
    logic             w_load_use;
    logic             w_pc_we;
    logic             w_ifid_we;
    logic             w_ifid_flush;
    logic             w_idex_we;
    logic             w_idex_bubble;
    logic             w_mc_busy;
    logic             w_mc_done;

    // r0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign w_load_use = (bus.ex_opcode == OPC_LW) && (bus.ex_rd != 5'd0) &&
                        ((bus.ex_rd == bus.id_rs) ||
                         (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

    always_comb begin
        w_state_next  = r_state;
        w_mc_cnt_next = r_mc_cnt;
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_we     = 1'b1;
        w_idex_bubble = 1'b0;
        w_mc_busy     = 1'b0;
        w_mc_done     = 1'b0;
        if (!reset_n) begin
            // Hold the whole front end and keep NOPs flowing while in reset.
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_idex_we     = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.ex_branch_tkn) begin
                        // Wrong-path instructions in IF and ID are squashed.
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end else if (bus.ex_opcode == OPC_MC) begin
                        w_pc_we       = 1'b0;
                        w_ifid_we     = 1'b0;
                        w_idex_we     = 1'b0;
                        w_state_next  = ST_MC_WAIT;
                        w_mc_cnt_next = MC_INIT;
                    end else if (w_load_use) begin
                        // The inserted bubble itself removes the hazard next cycle.
                        w_pc_we       = 1'b0;
                        w_ifid_we     = 1'b0;
                        w_idex_bubble = 1'b1;
                    end
                end
                default: begin
                    // EX is owned by the multi-cycle op; branch and load-use
                    // indications are not meaningful until it drains.
                    w_mc_busy = 1'b1;
                    if (r_mc_cnt != 4'd0) begin
                        w_pc_we       = 1'b0;
                        w_ifid_we     = 1'b0;
                        w_idex_we     = 1'b0;
                        w_mc_cnt_next = r_mc_cnt - 4'd1;
                    end else begin
                        w_mc_done    = 1'b1;
                        w_state_next = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_RUN;
            r_mc_cnt      <= 4'd0;
            r_stall_count <= '0;
        end else begin
            r_state  <= w_state_next;
            r_mc_cnt <= w_mc_cnt_next;
            if (!w_pc_we && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign bus.pc_we       = w_pc_we;
    assign bus.ifid_we     = w_ifid_we;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_we     = w_idex_we;
    assign bus.idex_bubble = w_idex_bubble;
    assign bus.mc_busy     = w_mc_busy;
    assign bus.mc_done     = w_mc_done;
    assign bus.stall_count = r_stall_count;
endmodule
